// File: rtl/pmips_pkg.sv
// pmips_pkg: shared opcode, predictor-counter and nop constants for the PMIPS fetch stage
package pmips_pkg;
  localparam logic [2:0] OP_JMP = 3'd7;
  localparam logic [2:0] OP_JAL = 3'd1;
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT = 2'd2;
  localparam logic [1:0] ST = 2'd3;
  localparam logic [15:0] NOP = 16'h0000;
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic inc);
    return inc ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/pmips_btb.sv
// pmips_btb: direct-mapped branch target buffer with 2-bit saturating predictors
module pmips_btb
  import pmips_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int BTB_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:1] lk_pc_i,
  output logic            lk_taken_o,
  output logic [XLEN-1:0] lk_target_o,
  input  logic            up_valid_i,
  input  logic [XLEN-1:1] up_pc_i,
  input  logic            up_taken_i,
  input  logic [XLEN-1:0] up_target_i
);
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - 1 - IDX;
  logic [BTB_DEPTH-1:0] valid_q;
  logic [TW-1:0] tag_q [BTB_DEPTH];
  logic [XLEN-1:0] tgt_q [BTB_DEPTH];
  logic [1:0] ctr_q [BTB_DEPTH];
  logic [IDX-1:0] lk_idx, up_idx;
  logic up_hit;
  assign lk_idx = lk_pc_i[IDX:1];
  assign up_idx = up_pc_i[IDX:1];
  assign up_hit = valid_q[up_idx] && tag_q[up_idx] == up_pc_i[XLEN-1:IDX+1];
  // Lookup reads the registered arrays, so a same-cycle update is not visible yet
  assign lk_taken_o = valid_q[lk_idx] && tag_q[lk_idx] == lk_pc_i[XLEN-1:IDX+1] && ctr_q[lk_idx][1];
  assign lk_target_o = tgt_q[lk_idx];
  // Train on resolved branches: taken allocates or strengthens, not-taken only weakens a hit
  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else if (up_valid_i && (up_taken_i || up_hit)) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx] <= up_hit ? ctr_step(ctr_q[up_idx], up_taken_i) : WT;
      if (up_taken_i) begin
        tag_q[up_idx] <= up_pc_i[XLEN-1:IDX+1];
        tgt_q[up_idx] <= up_target_i;
      end
    end
  end
endmodule

// File: rtl/pmips_fetch_unit.sv
// pmips_fetch_unit: PC, IF/ID register, fetch-stage jump decode and BTB prediction; PMIPS_FETCH_STATS_EN adds hit/mispredict counters
module pmips_fetch_unit
  import pmips_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int BTB_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  output logic [XLEN-1:0] imemaddr,
  input  logic [15:0]     imemrdata,
  output logic            ifid_valid,
  output logic [15:0]     ifid_instr,
  output logic [XLEN-1:0] ifid_pcplus2,
  output logic            ifid_pred_taken,
  output logic [XLEN-1:0] ifid_pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            flush,
  output logic [15:0]     hit_count,
  output logic [15:0]     mispredict_count
);
  logic [XLEN-1:0] pc_q, pc_d, pc_plus2, jmp_tgt, btb_tgt, pred_next;
  logic jump, btb_taken, pred_taken, mispredict;
  logic valid_q, pt_q;
  logic [15:0] instr_q;
  logic [XLEN-1:0] p2_q, ptg_q;
  pmips_btb #(.XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH)) u_btb (
    .clock(clock),
    .reset(reset),
    .lk_pc_i(pc_q[XLEN-1:1]),
    .lk_taken_o(btb_taken),
    .lk_target_o(btb_tgt),
    .up_valid_i(res_valid),
    .up_pc_i(res_pc[XLEN-1:1]),
    .up_taken_i(res_taken),
    .up_target_i(res_target)
  );
  assign pc_plus2 = pc_q + XLEN'(2);
  assign jump = imemrdata[15:13] == OP_JMP || imemrdata[15:13] == OP_JAL;
  assign jmp_tgt = {{(XLEN-13){imemrdata[12]}}, imemrdata[12:0]};
  assign pred_taken = jump || btb_taken;
  assign mispredict = res_valid && (res_taken != res_pred_taken || (res_taken && res_target != res_pred_target));
  assign flush = mispredict;
  assign imemaddr = pc_q;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pcplus2 = p2_q;
  assign ifid_pred_taken = pt_q;
  assign ifid_pred_target = ptg_q;
  // Next PC: redirect beats stall, jumps beat BTB, BTB beats sequential
  always_comb begin
    pred_next = jump ? jmp_tgt : btb_taken ? btb_tgt : pc_plus2;
    pc_d = mispredict ? (res_taken ? res_target : res_pc + XLEN'(2)) : stall ? pc_q : pred_next;
  end
  // PC and IF/ID register; a redirect squashes the fetched slot even under stall
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      p2_q <= '0;
      pt_q <= 1'b0;
      ptg_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (mispredict) begin
        valid_q <= 1'b0;
        instr_q <= NOP;
        pt_q <= 1'b0;
      end else if (!stall) begin
        valid_q <= 1'b1;
        instr_q <= imemrdata;
        p2_q <= pc_plus2;
        pt_q <= pred_taken;
        ptg_q <= pred_next;
      end
    end
  end
`ifdef PMIPS_FETCH_STATS_EN
  logic [15:0] hit_q, mis_q;
  // Saturating counters of used BTB-taken predictions and of redirects
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q <= '0;
      mis_q <= '0;
    end else begin
      if (!stall && !mispredict && !jump && btb_taken && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      if (mispredict && mis_q != 16'hFFFF) mis_q <= mis_q + 16'd1;
    end
  end
  assign hit_count = hit_q;
  assign mispredict_count = mis_q;
`else
  assign hit_count = '0;
  assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_pmips_fetch_unit.sv
// tb_pmips_fetch_unit: directed and random fetch-stage checks against a behavioural model
module tb_pmips_fetch_unit;
  localparam int D = 8;
  logic clock = 1'b0;
  logic reset, stall, res_valid, res_taken, res_pred_taken;
  logic [15:0] imemaddr, imemrdata, ifid_instr, ifid_pcplus2, ifid_pred_target;
  logic [15:0] res_pc, res_target, res_pred_target, hit_count, mispredict_count;
  logic ifid_valid, ifid_pred_taken, flush;
  logic [15:0] mem [0:32767];
  int n_checks = 0, n_fail = 0;
  logic last_flush;
  logic m_known = 1'b0;
  logic [15:0] m_pc, m_instr, m_p2, m_ptg;
  logic m_v, m_pt;
  bit bv [D];
  logic [15:0] bpc [D], btg [D];
  int bctr [D];
  int m_hits, m_mis;

  always #5 clock = ~clock;
  assign imemrdata = mem[imemaddr[15:1]];

  pmips_fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .imemaddr(imemaddr), .imemrdata(imemrdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pcplus2(ifid_pcplus2),
    .ifid_pred_taken(ifid_pred_taken), .ifid_pred_target(ifid_pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target), .flush(flush),
    .hit_count(hit_count), .mispredict_count(mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic rv, input logic [15:0] rpc,
                     input logic rt, input logic [15:0] rtg, input logic rpt, input logic [15:0] rptg);
    logic [15:0] inst, jt, pn, np;
    logic jump, hit, btkn, mis;
    int idx, ui;
    @(negedge clock);
    reset = rst; stall = st; res_valid = rv; res_pc = rpc; res_taken = rt;
    res_target = rtg; res_pred_taken = rpt; res_pred_target = rptg;
    #1;
    last_flush = flush;
    inst = mem[m_pc >> 1];
    jump = (inst >> 13) == 7 || (inst >> 13) == 1;
    jt = (inst & 16'h1000) != 0 ? (inst | 16'hE000) : (inst & 16'h1FFF);
    idx = (m_pc / 2) % D;
    hit = bv[idx] && bpc[idx] == m_pc;
    btkn = hit && bctr[idx] >= 2;
    mis = rv && (rt != rpt || (rt && rtg != rptg));
    pn = jump ? jt : btkn ? btg[idx] : m_pc + 16'd2;
    if (m_known) begin
      chk("imemaddr", imemaddr, m_pc);
      chk("flush", flush, mis);
      chk("ifid_valid", ifid_valid, m_v);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pcplus2", ifid_pcplus2, m_p2);
      chk("ifid_pred_taken", ifid_pred_taken, m_pt);
      if (m_pt) chk("ifid_pred_target", ifid_pred_target, m_ptg);
`ifdef PMIPS_FETCH_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("mispredict_count", mispredict_count, m_mis);
`else
      chk("hit_count", hit_count, 0);
      chk("mispredict_count", mispredict_count, 0);
`endif
    end
    @(posedge clock);
    if (rst) begin
      m_known = 1'b1;
      m_pc = 0; m_v = 0; m_instr = 0; m_p2 = 0; m_pt = 0; m_ptg = 0;
      m_hits = 0; m_mis = 0;
      for (int i = 0; i < D; i++) bv[i] = 0;
    end else begin
      if (!st && !mis && !jump && btkn && m_hits < 65535) m_hits++;
      if (mis && m_mis < 65535) m_mis++;
      np = mis ? (rt ? rtg : rpc + 16'd2) : st ? m_pc : pn;
      if (mis) begin
        m_v = 0; m_instr = 0; m_pt = 0;
      end else if (!st) begin
        m_v = 1; m_instr = inst; m_p2 = m_pc + 16'd2; m_pt = jump || btkn; m_ptg = pn;
      end
      m_pc = np;
      if (rv) begin
        ui = (rpc / 2) % D;
        if (rt) begin
          bctr[ui] = (bv[ui] && bpc[ui] == rpc) ? (bctr[ui] < 3 ? bctr[ui] + 1 : 3) : 2;
          bv[ui] = 1; bpc[ui] = rpc; btg[ui] = rtg;
        end else if (bv[ui] && bpc[ui] == rpc) bctr[ui] = bctr[ui] > 0 ? bctr[ui] - 1 : 0;
      end
    end
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, st, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic res(input logic st, input logic [15:0] rpc, input logic rt, input logic [15:0] rtg,
                     input logic rpt, input logic [15:0] rptg);
    cyc(1'b0, st, 1'b1, rpc, rt, rtg, rpt, rptg);
  endtask

  initial begin
    logic [15:0] s_addr, s_instr, s_p2, s_ptg;
    logic s_v, s_pt, rt, rpt;
    logic [15:0] rtg;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[2] = 16'hE010;
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    #2;
    chk("reset_pc", imemaddr, 16'h0000);
    chk("reset_valid", ifid_valid, 1'b0);
    idle(1'b0); #2;
    chk("seq_pc2", imemaddr, 16'h0002);
    chk("valid_after_reset", ifid_valid, 1'b1);
    idle(1'b0); #2;
    chk("seq_pc4", imemaddr, 16'h0004);
    idle(1'b0); #2;
    chk("jump_pc", imemaddr, 16'h0010);
    chk("jump_pred_taken", ifid_pred_taken, 1'b1);
    chk("jump_pred_target", ifid_pred_target, 16'h0010);
    res(1'b0, 16'd8, 1'b1, 16'd20, 1'b0, 16'd0); #2;
    chk("mis_flush", last_flush, 1'b1);
    chk("mis_redirect", imemaddr, 16'd20);
    chk("mis_nop", ifid_instr, 16'h0000);
    chk("mis_invalid", ifid_valid, 1'b0);
    res(1'b0, 16'd6, 1'b0, 16'd0, 1'b1, 16'd0); #2;
    chk("redirect_to_8", imemaddr, 16'd8);
    idle(1'b0); #2;
    chk("btb_no_flush", last_flush, 1'b0);
    chk("btb_pred_pc", imemaddr, 16'd20);
    chk("btb_pred_taken", ifid_pred_taken, 1'b1);
    chk("btb_pred_target", ifid_pred_target, 16'd20);
    res(1'b0, 16'd8, 1'b1, 16'd20, 1'b1, 16'd20);
    chk("correct_no_flush", last_flush, 1'b0);
    res(1'b0, 16'd8, 1'b0, 16'd0, 1'b0, 16'd0);
    res(1'b0, 16'd8, 1'b0, 16'd0, 1'b0, 16'd0);
    res(1'b0, 16'd6, 1'b0, 16'd0, 1'b1, 16'd0);
    idle(1'b0); #2;
    chk("weak_nt_pc", imemaddr, 16'd10);
    chk("weak_nt_pred", ifid_pred_taken, 1'b0);
    res(1'b1, 16'd8, 1'b0, 16'd0, 1'b1, 16'd20); #2;
    chk("flush_over_stall", last_flush, 1'b1);
    chk("flush_over_stall_pc", imemaddr, 16'd10);
    chk("flush_over_stall_valid", ifid_valid, 1'b0);
    idle(1'b0); #2;
    s_addr = imemaddr; s_v = ifid_valid; s_instr = ifid_instr; s_p2 = ifid_pcplus2;
    s_pt = ifid_pred_taken; s_ptg = ifid_pred_target;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1); #2;
      chk("stall_pc", imemaddr, s_addr);
      chk("stall_valid", ifid_valid, s_v);
      chk("stall_instr", ifid_instr, s_instr);
      chk("stall_p2", ifid_pcplus2, s_p2);
      chk("stall_pt", ifid_pred_taken, s_pt);
      chk("stall_ptg", ifid_pred_target, s_ptg);
    end
    for (int i = 0; i < 128; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) mem[i] = {(r == 0 ? 3'd7 : 3'd1), 13'($urandom_range(0, 127) * 2)};
      else mem[i] = {3'($urandom_range(0, 5) == 0 ? 0 : $urandom_range(2, 6)), 13'($urandom)};
    end
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 16'd0);
    for (int n = 0; n < 3000; n++) begin
      rt = 1'($urandom);
      rtg = 16'($urandom_range(0, 127) * 2);
      rpt = $urandom_range(0, 3) == 0 ? ~rt : rt;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
          16'($urandom_range(0, 31) * 2), rt, rtg, rpt,
          $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 127) * 2) : rtg);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
